// File: rtl/clmul_pkg.sv
// clmul_pkg: shared state encoding, default widths and Karatsuba recombination for the carry-less multiplier.
package clmul_pkg;
  typedef enum logic [2:0] {IDLE, LO, HI, MID, OUT} state_t;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_HALF = DEF_WIDTH / 2;
  localparam int MAX_WIDTH = 64;
  // Terms arrive zero-extended to a fixed maximum so one function serves every WIDTH up to MAX_WIDTH.
  function automatic logic [2*MAX_WIDTH-2:0] clmul_combine(input logic [MAX_WIDTH-2:0] z0, m, z2, input int half);
    logic [2*MAX_WIDTH-2:0] z0x, midx, z2x;
    z0x = {{MAX_WIDTH{1'b0}}, z0};
    midx = {{MAX_WIDTH{1'b0}}, m ^ z0 ^ z2};
    z2x = {{MAX_WIDTH{1'b0}}, z2};
    return z0x ^ (midx << half) ^ (z2x << (2 * half));
  endfunction
endpackage

// File: rtl/clmul_karatsuba_seq_if.sv
// clmul_karatsuba_seq_if: operand/result handshake bundle between producer, multiplier and consumer.
interface clmul_karatsuba_seq_if import clmul_pkg::*; #(parameter int WIDTH = DEF_WIDTH);
  logic in_valid, in_ready, out_valid, out_ready, busy;
  logic [WIDTH-1:0] a, b;
  logic [2*WIDTH-2:0] p;
  modport master(output in_valid, a, b, out_ready, input in_ready, out_valid, p, busy);
  modport slave(input in_valid, a, b, out_ready, output in_ready, out_valid, p, busy);
endinterface

// File: rtl/clmul_half.sv
// clmul_half: combinational HALF x HALF carry-less product as an AND/XOR array.
module clmul_half import clmul_pkg::*; #(parameter int HALF = DEF_HALF) (
  input  logic [HALF-1:0]   a,
  input  logic [HALF-1:0]   b,
  output logic [2*HALF-2:0] p
);
  always_comb begin
    p = '0;
    for (int i = 0; i < HALF; i++) p = p ^ ({{(HALF-1){1'b0}}, b & {HALF{a[i]}}} << i);
  end
endmodule

// File: rtl/clmul_karatsuba_seq.sv
// clmul_karatsuba_seq: sequential Karatsuba carry-less multiplier sharing one half-width product unit over three cycles.
module clmul_karatsuba_seq import clmul_pkg::*; #(parameter int WIDTH = DEF_WIDTH) (
  input logic                 clk,
  input logic                 rst_n,
  clmul_karatsuba_seq_if.slave bus
);
  localparam int HALF = WIDTH / 2;
  localparam int ZW = 2 * HALF - 1;
  localparam int PW = 2 * WIDTH - 1;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [ZW-1:0] z0_q, z0_d, z2_q, z2_d, hp;
  logic [PW-1:0] p_q, p_d;
  logic [HALF-1:0] ha, hb;
  logic accept;
  assign bus.in_ready = (state_q == IDLE) || (state_q == OUT && bus.out_ready);
  assign bus.out_valid = state_q == OUT;
  assign bus.busy = state_q != IDLE;
  assign bus.p = p_q;
  assign accept = bus.in_valid & bus.in_ready;
  assign ha = state_q == HI ? a_q[WIDTH-1:HALF] : state_q == MID ? a_q[HALF-1:0] ^ a_q[WIDTH-1:HALF] : a_q[HALF-1:0];
  assign hb = state_q == HI ? b_q[WIDTH-1:HALF] : state_q == MID ? b_q[HALF-1:0] ^ b_q[WIDTH-1:HALF] : b_q[HALF-1:0];
  clmul_half #(.HALF(HALF)) u_half (.a(ha), .b(hb), .p(hp));
  always_comb begin
    a_d = accept ? bus.a : a_q;
    b_d = accept ? bus.b : b_q;
    z0_d = state_q == LO ? hp : z0_q;
    z2_d = state_q == HI ? hp : z2_q;
    p_d = state_q == MID ? PW'(clmul_combine((MAX_WIDTH-1)'(z0_q), (MAX_WIDTH-1)'(hp), (MAX_WIDTH-1)'(z2_q), HALF)) : p_q;
    case (state_q)
      IDLE:    state_d = accept ? LO : IDLE;
      LO:      state_d = HI;
      HI:      state_d = MID;
      MID:     state_d = OUT;
      OUT:     state_d = !bus.out_ready ? OUT : bus.in_valid ? LO : IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      z0_q <= '0;
      z2_q <= '0;
      p_q <= '0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      z0_q <= z0_d;
      z2_q <= z2_d;
      p_q <= p_d;
    end
  end
endmodule

// File: tb/tb_clmul_karatsuba_seq.sv
// tb_clmul_karatsuba_seq: directed self-checking bench for the sequential Karatsuba carry-less multiplier.
module tb_clmul_karatsuba_seq;
  logic clk = 0;
  logic rst_n = 0;
  int total = 0;
  int bad = 0;
  clmul_karatsuba_seq_if #(.WIDTH(16)) bus ();
  clmul_karatsuba_seq #(.WIDTH(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  function automatic logic [30:0] ref_clmul(input logic [15:0] x, input logic [15:0] y);
    logic [30:0] r = '0;
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        if (x[i] & y[j]) r[i+j] = ~r[i+j];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] x, input logic [15:0] y);
    bus.in_valid = 1;
    bus.a = x;
    bus.b = y;
    tick();
    bus.in_valid = 0;
    bus.a = 'x;
    bus.b = 'x;
  endtask

  task automatic test_reset();
    bus.in_valid = 0;
    bus.a = '0;
    bus.b = '0;
    bus.out_ready = 1;
    rst_n = 0;
    tick();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
    total++; if (bus.p !== 31'h0) begin bad++; $display("FAIL reset_p got=%h want=0", bus.p); end
    rst_n = 1;
    tick();
  endtask

  task automatic test_basic();
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL basic_in_ready got=%b want=1", bus.in_ready); end
    send(16'h0003, 16'h0003);
    total++; if (bus.busy !== 1'b1 || bus.out_valid !== 1'b0) begin bad++; $display("FAIL basic_lo busy=%b ov=%b want 1/0", bus.busy, bus.out_valid); end
    for (int c = 1; c <= 3; c++) begin
      tick();
      total++; if (bus.busy !== 1'b1 || bus.out_valid !== (c == 3)) begin bad++; $display("FAIL basic_lat c=%0d busy=%b ov=%b", c, bus.busy, bus.out_valid); end
    end
    total++; if (bus.p !== 31'h5) begin bad++; $display("FAIL basic_p got=%h want=00000005", bus.p); end
    tick();
    total++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("FAIL basic_idle ov=%b busy=%b want 0/0", bus.out_valid, bus.busy); end
  endtask

  task automatic test_patterns();
    logic [15:0] va [3] = '{16'hFFFF, 16'h8000, 16'h0100};
    logic [15:0] vb [3] = '{16'hFFFF, 16'h8000, 16'h0001};
    logic [30:0] vp [3] = '{31'h55555555, 31'h40000000, 31'h00000100};
    for (int i = 0; i < 3; i++) begin
      send(va[i], vb[i]);
      repeat (3) tick();
      total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL pat%0d_valid got=%b want=1", i, bus.out_valid); end
      total++; if (bus.p !== vp[i]) begin bad++; $display("FAIL pat%0d_p got=%h want=%h", i, bus.p, vp[i]); end
      tick();
    end
  endtask

  task automatic test_backpressure();
    bus.out_ready = 0;
    send(16'h0005, 16'h0003);
    repeat (3) tick();
    for (int c = 0; c < 10; c++) begin
      total++; if (bus.out_valid !== 1'b1 || bus.p !== 31'hF || bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_hold c=%0d ov=%b p=%h rdy=%b want 1/0000000f/0", c, bus.out_valid, bus.p, bus.in_ready); end
      tick();
    end
    bus.out_ready = 1;
    bus.in_valid = 1;
    bus.a = 16'h1234;
    bus.b = 16'h0001;
    #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_in_ready got=%b want=1", bus.in_ready); end
    tick();
    bus.in_valid = 0;
    total++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b1) begin bad++; $display("FAIL bp_accept ov=%b busy=%b want 0/1", bus.out_valid, bus.busy); end
    repeat (3) tick();
    total++; if (bus.out_valid !== 1'b1 || bus.p !== 31'h1234) begin bad++; $display("FAIL bp_next ov=%b p=%h want 1/00001234", bus.out_valid, bus.p); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [15:0] va [8];
    logic [15:0] vb [8];
    for (int i = 0; i < 8; i++) begin
      va[i] = 16'($urandom);
      vb[i] = 16'($urandom);
    end
    bus.out_ready = 1;
    bus.in_valid = 1;
    bus.a = va[0];
    bus.b = vb[0];
    tick();
    for (int i = 0; i < 8; i++) begin
      if (i < 7) begin
        bus.a = va[i+1];
        bus.b = vb[i+1];
      end else bus.in_valid = 0;
      for (int c = 1; c <= 3; c++) begin
        tick();
        total++; if (bus.busy !== 1'b1 || bus.out_valid !== (c == 3)) begin bad++; $display("FAIL b2b%0d_c%0d busy=%b ov=%b", i, c, bus.busy, bus.out_valid); end
      end
      total++; if (bus.p !== ref_clmul(va[i], vb[i])) begin bad++; $display("FAIL b2b%0d_p got=%h want=%h", i, bus.p, ref_clmul(va[i], vb[i])); end
      tick();
    end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL b2b_end_busy got=%b want=0", bus.busy); end
  endtask

  task automatic test_ignore_input();
    logic [15:0] junk [3] = '{16'hFFFF, 16'hABCD, 16'h5A5A};
    send(16'h0007, 16'h0005);
    for (int c = 0; c < 3; c++) begin
      total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL ign_in_ready c=%0d got=%b want=0", c, bus.in_ready); end
      bus.in_valid = (c != 2) ? ~bus.in_valid : 1'b0;
      bus.a = junk[c];
      bus.b = ~junk[c];
      tick();
    end
    total++; if (bus.out_valid !== 1'b1 || bus.p !== 31'h1B) begin bad++; $display("FAIL ign_p ov=%b p=%h want 1/0000001b", bus.out_valid, bus.p); end
    tick();
  endtask

  task automatic test_async_reset();
    send(16'h0001, 16'h0001);
    tick();
    rst_n = 0;
    #1;
    total++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin bad++; $display("FAIL areset ov=%b busy=%b rdy=%b want 0/0/1", bus.out_valid, bus.busy, bus.in_ready); end
    total++; if (bus.p !== 31'h0) begin bad++; $display("FAIL areset_p got=%h want=0", bus.p); end
    #2;
    rst_n = 1;
    tick();
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL areset_idle busy=%b want=0", bus.busy); end
    send(16'h00FF, 16'h0101);
    repeat (3) tick();
    total++; if (bus.out_valid !== 1'b1 || bus.p !== 31'hFFFF) begin bad++; $display("FAIL areset_next ov=%b p=%h want 1/0000ffff", bus.out_valid, bus.p); end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_patterns();
    test_backpressure();
    test_back_to_back();
    test_ignore_input();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
